// File: rtl/fifo_pkg.sv
// fifo_pkg: widths and occupancy type shared by the FIFO read stream, its buffer and the bench.
package fifo_pkg;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order buffer with head/tail pointers and occupancy count.
module fifo_rd_skid #(
    parameter int DATA_W = fifo_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              i_clr,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd,
    output fifo_pkg::occ_t    o_cnt,
    output logic [DATA_W-1:0] o_head
);
    import fifo_pkg::*;
    logic [DATA_W-1:0] r_mem [2];
    logic              r_head;
    logic              r_tail;
    occ_t              r_cnt;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (i_wr) begin
                r_mem[r_tail] <= i_wdata;
                r_tail        <= ~r_tail;
            end
            if (i_rd) r_head <= ~r_head;
            r_cnt <= r_cnt + occ_t'(i_wr) - occ_t'(i_rd);
        end
    end
    assign o_cnt  = r_cnt;
    // stale entries stay hidden once drained or flushed
    assign o_head = (r_cnt != '0) ? r_mem[r_head] : '0;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a FIFO with one-cycle read latency and presents the words as a valid/ready stream.
module fifo_rd_stream #(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int CNT_W  = fifo_pkg::CNT_W
) (
    input  logic              rdclk,
    input  logic              arst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_pop,
    input  logic              flush,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  xfer_cnt
);
    import fifo_pkg::*;
    occ_t             w_cnt;
    logic             w_hs;
    logic [2:0]       w_occ_next;
    logic             r_inflight;
    logic [CNT_W-1:0] r_xfer;
    assign m_valid    = (w_cnt != '0);
    assign w_hs       = m_valid && m_ready;
    assign w_occ_next = 3'(w_cnt) + 3'(r_inflight) - 3'(w_hs);
    // gating on arst_n keeps the FIFO untouched while the block is held in reset
    assign fifo_pop   = arst_n && !fifo_empty && !flush && (w_occ_next < 3'd2);
    assign xfer_cnt   = r_xfer;
    always_ff @(posedge rdclk or negedge arst_n) begin
        if (!arst_n) begin
            r_inflight <= 1'b0;
            r_xfer     <= '0;
        end else begin
            r_inflight <= fifo_pop;
            r_xfer     <= r_xfer + CNT_W'(w_hs);
        end
    end
    fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
        .clk     (rdclk),
        .arst_n  (arst_n),
        .i_clr   (flush),
        .i_wr    (r_inflight),
        .i_wdata (fifo_rdata),
        .i_rd    (w_hs),
        .o_cnt   (w_cnt),
        .o_head  (m_data)
    );
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO environment plus queue-based reference model of the read stream.
module tb_fifo_rd_stream;
    import fifo_pkg::*;
    logic              rdclk = 1'b0;
    logic              arst_n = 1'b1;
    logic              fifo_empty = 1'b1;
    logic              flush = 1'b0;
    logic              m_ready = 1'b0;
    logic [DATA_W-1:0] fifo_rdata = '0;
    logic              fifo_pop;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  xfer_cnt;
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] mdl_q[$];
    logic [DATA_W-1:0] got_q[$];
    bit                mdl_infl = 1'b0;
    logic [DATA_W-1:0] mdl_word = '0;
    logic [CNT_W-1:0]  mdl_xfer = '0;
    bit                exp_pop, exp_valid, exp_hs;
    logic [DATA_W-1:0] exp_data;
    logic [CNT_W+DATA_W+1:0] got_v, exp_v;

    always #5 rdclk = ~rdclk;

    fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .rdclk(rdclk), .arst_n(arst_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_pop(fifo_pop), .flush(flush), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .xfer_cnt(xfer_cnt)
    );

    function automatic bit drained();
        return src_q.size() == 0 && mdl_q.size() == 0 && !mdl_infl;
    endfunction

    // Drive inputs at the falling edge, predict outputs from the model, sample the DUT.
    task automatic set_inputs(input bit rdy, input bit fl, input bit hold);
        m_ready    = rdy;
        flush      = fl;
        fifo_empty = hold || (src_q.size() == 0);
        exp_valid  = (mdl_q.size() != 0);
        exp_data   = exp_valid ? mdl_q[0] : '0;
        exp_hs     = exp_valid && rdy;
        exp_pop    = arst_n && !fifo_empty && !fl && (mdl_q.size() + int'(mdl_infl) - int'(exp_hs) < 2);
        exp_v      = {exp_pop, exp_valid, exp_data, mdl_xfer};
        #1;
        got_v = {fifo_pop, m_valid, m_data & {DATA_W{m_valid}}, xfer_cnt};
        if (m_valid && m_ready) got_q.push_back(m_data);
    endtask

    // Rising edge: advance the model, then let the FIFO return the popped word.
    task automatic advance();
        bit                popped;
        logic [DATA_W-1:0] nxt;
        popped = fifo_pop;
        nxt = (exp_pop && src_q.size() > 0) ? src_q[0] : '0;
        @(posedge rdclk);
        if (!arst_n || flush) begin
            mdl_q.delete();
            mdl_infl = 1'b0;
        end else begin
            if (exp_hs) void'(mdl_q.pop_front());
            if (mdl_infl) mdl_q.push_back(mdl_word);
            mdl_infl = exp_pop;
        end
        mdl_word = nxt;
        if (!arst_n) mdl_xfer = '0;
        else if (exp_hs) mdl_xfer = mdl_xfer + 1'b1;
        #1;
        if (popped && src_q.size() > 0) fifo_rdata = src_q.pop_front();
        else fifo_rdata = DATA_W'($urandom);
        @(negedge rdclk);
    endtask

    task automatic hold_reset();
        arst_n = 1'b0;
        mdl_q.delete();
        mdl_infl = 1'b0;
        mdl_xfer = '0;
        set_inputs(0, 0, 1);
        advance();
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        src_q = {8'hA5, 8'h5A};
        #1 arst_n = 1'b0;
        @(negedge rdclk);
        for (int c = 0; c < 2; c++) begin
            set_inputs(1, 0, 0);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL reset_state cyc %0d got %h exp %h", c, got_v, exp_v); end
            checks++;
            if (m_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 00", m_data); end
            advance();
        end
        arst_n = 1'b1;
        src_q.delete();
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] words[$];
        logic [CNT_W-1:0]  start;
        words = {8'h11, 8'h22, 8'h33};
        src_q = words;
        got_q.delete();
        start = mdl_xfer;
        for (int c = 0; c < 6; c++) begin
            set_inputs(1, 0, 0);
            if (c == 0) begin
                checks++;
                if (fifo_pop !== 1'b1) begin errors++; $display("FAIL stream_first_pop got %b exp 1", fifo_pop); end
            end
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL stream cyc %0d got %h exp %h", c, got_v, exp_v); end
            advance();
        end
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL stream_count got %0d exp 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== words[i]) begin errors++; $display("FAIL stream_word %0d got %h exp %h", i, got_q[i], words[i]); end
        end
        checks++;
        if (xfer_cnt !== start + 3) begin errors++; $display("FAIL stream_xfer got %0d exp %0d", xfer_cnt, start + 3); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] words[$];
        int pops;
        for (int i = 0; i < 5; i++) words.push_back(DATA_W'($urandom));
        src_q = words;
        got_q.delete();
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            set_inputs(0, 0, 0);
            pops += int'(fifo_pop);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL bp_stall cyc %0d got %h exp %h", c, got_v, exp_v); end
            advance();
        end
        checks++;
        if (pops != 2) begin errors++; $display("FAIL bp_pops got %0d exp 2", pops); end
        checks++;
        if (m_valid !== 1'b1 || m_data !== words[0]) begin errors++; $display("FAIL bp_head got %b/%h exp 1/%h", m_valid, m_data, words[0]); end
        for (int c = 0; c < 30 && !drained(); c++) begin
            set_inputs(1, 0, 0);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL bp_drain cyc %0d got %h exp %h", c, got_v, exp_v); end
            advance();
        end
        checks++;
        if (got_q.size() != words.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), words.size()); end
        for (int i = 0; i < words.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== words[i]) begin errors++; $display("FAIL bp_word %0d got %h exp %h", i, got_q[i], words[i]); end
        end
    endtask

    task automatic test_toggle();
        logic [DATA_W-1:0] words[$];
        for (int i = 0; i < 20; i++) words.push_back(DATA_W'($urandom));
        src_q = words;
        got_q.delete();
        for (int c = 0; c < 200 && !drained(); c++) begin
            set_inputs(c[0], 0, 0);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL toggle cyc %0d got %h exp %h", c, got_v, exp_v); end
            advance();
        end
        checks++;
        if (got_q.size() != 20) begin errors++; $display("FAIL toggle_count got %0d exp 20", got_q.size()); end
        for (int i = 0; i < 20 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== words[i]) begin errors++; $display("FAIL toggle_word %0d got %h exp %h", i, got_q[i], words[i]); end
        end
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] words[$];
        logic [CNT_W-1:0]  xb;
        for (int i = 0; i < 6; i++) words.push_back(DATA_W'($urandom));
        src_q = words;
        got_q.delete();
        for (int c = 0; c < 2; c++) begin
            set_inputs(0, 0, 0);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL flush_fill cyc %0d got %h exp %h", c, got_v, exp_v); end
            advance();
        end
        xb = mdl_xfer;
        set_inputs(0, 1, 0);
        checks++;
        if (fifo_pop !== 1'b0) begin errors++; $display("FAIL flush_pop got %b exp 0", fifo_pop); end
        checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL flush_cycle got %h exp %h", got_v, exp_v); end
        advance();
        set_inputs(0, 0, 1);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", m_valid); end
        checks++;
        if (xfer_cnt !== xb) begin errors++; $display("FAIL flush_xfer got %0d exp %0d", xfer_cnt, xb); end
        advance();
        for (int c = 0; c < 30 && !drained(); c++) begin
            set_inputs(1, 0, 0);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL flush_drain cyc %0d got %h exp %h", c, got_v, exp_v); end
            advance();
        end
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL flush_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== words[i+2]) begin errors++; $display("FAIL flush_word %0d got %h exp %h", i, got_q[i], words[i+2]); end
        end
    endtask

    task automatic test_random();
        bit rdy, fl, hold;
        for (int c = 0; c < 400; c++) begin
            if (src_q.size() < 3 && $urandom_range(0, 1) == 1) src_q.push_back(DATA_W'($urandom));
            fl   = ($urandom_range(0, 19) == 0);
            rdy  = !fl && ($urandom_range(0, 3) != 0);
            hold = ($urandom_range(0, 3) == 0);
            set_inputs(rdy, fl, hold);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL random cyc %0d got %h exp %h", c, got_v, exp_v); end
            advance();
        end
        for (int c = 0; c < 30 && !drained(); c++) begin
            set_inputs(1, 0, 0);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL random_drain cyc %0d got %h exp %h", c, got_v, exp_v); end
            advance();
        end
    endtask

    task automatic test_async_reset();
        logic [DATA_W-1:0] words[$];
        for (int i = 0; i < 5; i++) words.push_back(DATA_W'($urandom));
        src_q = words;
        got_q.delete();
        for (int c = 0; c < 3; c++) begin
            set_inputs(0, 0, 0);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL arst_fill cyc %0d got %h exp %h", c, got_v, exp_v); end
            advance();
        end
        set_inputs(0, 0, 0);
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", m_valid); end
        arst_n = 1'b0;
        mdl_q.delete();
        mdl_infl = 1'b0;
        mdl_xfer = '0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || fifo_pop !== 1'b0 || xfer_cnt !== '0) begin errors++; $display("FAIL arst_immediate got v%b p%b x%0d exp v0 p0 x0", m_valid, fifo_pop, xfer_cnt); end
        set_inputs(0, 0, 0);
        checks++;
        if (got_v !== exp_v) begin errors++; $display("FAIL arst_hold got %h exp %h", got_v, exp_v); end
        advance();
        arst_n = 1'b1;
        got_q.delete();
        for (int c = 0; c < 30 && !drained(); c++) begin
            set_inputs(1, 0, 0);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL arst_drain cyc %0d got %h exp %h", c, got_v, exp_v); end
            advance();
        end
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL arst_count got %0d exp 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== words[i+2]) begin errors++; $display("FAIL arst_word %0d got %h exp %h", i, got_q[i], words[i+2]); end
        end
    endtask

    task automatic test_wrap();
        hold_reset();
        got_q.delete();
        for (int c = 0; c < 70000 && mdl_xfer != {CNT_W{1'b1}}; c++) begin
            while (src_q.size() < 4) src_q.push_back(DATA_W'($urandom));
            set_inputs(1, 0, 0);
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL wrap_run cyc %0d got %h exp %h", c, got_v, exp_v); end
            if (got_q.size() > 8) got_q.delete();
            advance();
        end
        set_inputs(1, 0, 0);
        checks++;
        if (xfer_cnt !== {CNT_W{1'b1}} || m_valid !== 1'b1) begin errors++; $display("FAIL wrap_max got x%0d v%b exp x65535 v1", xfer_cnt, m_valid); end
        advance();
        set_inputs(0, 0, 1);
        checks++;
        if (xfer_cnt !== '0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", xfer_cnt); end
        advance();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_flush();
        test_random();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
